isa_decode_mc: RTL and testbench

- Parametrised, multi-channel successor to the single-trigger ISA decoder. Sits in the read-clock domain after the ISA capturer.
- Consumes {addr, data, mask} instruction beats over a valid/ready handshake and decodes them against a base-relative address map.
- Drives per-channel trigger pulse, count and step registers and a wait accumulator.
- Buffers forwarded pulse/play/trigger beats in a FWFT FIFO that drains under downstream backpressure (I_tx_ready).

---
 rtl/isa_decode_mc.sv | 212 +++++++++++++++++++++
 tb/tb_isa_decode_mc.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/isa_decode_mc.sv
// isa_decode_mc: decodes {addr,data,mask} beats into trigger/step/wait registers and queues forwarded beats for TX.
// Latency: register updates and O_Trig appear one cycle after accept; a pushed beat is on O_tx_* the next cycle (FWFT).
// Backpressure: O_isa_ready drops while the TX FIFO is full (or while stalled); the FIFO drains whenever I_tx_ready is high.
// Optional feature: ISA_DECODE_QWAIT_STALL_EN makes a non-zero qwait block input for N cycles.

// Small generic first-word-fall-through FIFO; storage is cleared on reset so an empty head reads as zero.
module isa_decode_mc_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_vld_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic         head_vld_o,
    output logic [W-1:0] head_dat_o,
    output logic         full_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   cnt_q;

    // Pointers wrap naturally (power-of-two depth); push+pop together leaves the count unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_vld_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)      rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_vld_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push_vld_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    assign head_vld_o = (cnt_q != '0);
    assign head_dat_o = mem_q[rd_ptr_q];
    assign full_o     = (cnt_q == (PW + 1)'(DEPTH));
endmodule

module isa_decode_mc #(
    parameter int              ADDR_W     = 32,
    parameter int              DATA_W     = 32,
    parameter int              NUM_CH     = 4,
    parameter int              FIFO_DEPTH = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h0200_0000)
) (
    input  logic                     I_clk,
    input  logic                     I_rst_n,
    input  logic                     I_isa_valid,
    output logic                     O_isa_ready,
    input  logic [ADDR_W-1:0]        I_isa_addr,
    input  logic [DATA_W-1:0]        I_isa_data,
    input  logic [3:0]               I_isa_mask,
    output logic [ADDR_W+DATA_W-1:0] O_tx_data,
    output logic                     O_tx_en,
    input  logic                     I_tx_ready,
    output logic [NUM_CH-1:0]        O_Trig,
    output logic [NUM_CH*32-1:0]     O_Trig_Num,
    output logic [NUM_CH*32-1:0]     O_Trig_Step,
    output logic [31:0]              O_Wait,
    output logic [15:0]              O_err_cnt
);
    typedef enum logic {ST_IDLE, ST_STALL} state_e;

    state_e                 state_q, state_d;
    logic                   isa_rdy;
    logic                   fifo_full;
    logic                   acc;
    logic                   legal;
    logic [ADDR_W-1:0]      off;
    logic [31:0]            data32;
    logic [NUM_CH-1:0]      trig_sel;
    logic [NUM_CH-1:0]      step_sel;
    logic                   trig_hit, step_hit, wclr_hit, wadd_hit;
    logic                   pulse_hit, play_hit, fmr_hit;
    logic                   do_trig, do_wclr, do_wadd, do_push, do_err;

    logic [NUM_CH-1:0]      trig_q;
    logic [NUM_CH*32-1:0]   num_q;
    logic [NUM_CH*32-1:0]   step_q;
    logic [31:0]            wait_q;
    logic [15:0]            err_q;

    assign data32  = 32'(I_isa_data);
    assign isa_rdy = I_rst_n && (state_q == ST_IDLE) && !fifo_full;
    assign acc     = I_isa_valid && isa_rdy;
    assign legal   = (I_isa_mask == 4'hF);

    // Address decode relative to BASE_ADDR; qualified with accept/legal to form the action strobes.
    always_comb begin
        off      = I_isa_addr - BASE_ADDR;
        trig_sel = '0;
        step_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (off == ADDR_W'(32'h1000 + 8 * c)) trig_sel[c] = 1'b1;
            if (off == ADDR_W'(32'h1004 + 8 * c)) step_sel[c] = 1'b1;
        end
        trig_hit  = |trig_sel;
        step_hit  = |step_sel;
        wclr_hit  = (off == ADDR_W'(32'h1FFC));
        wadd_hit  = (off == ADDR_W'(32'h2000));
        pulse_hit = (off >= ADDR_W'(32'h23F8)) && (off <= ADDR_W'(32'h2800));
        play_hit  = (off >= ADDR_W'(32'h8000)) && (off <= ADDR_W'(32'h52000));
        fmr_hit   = (off == ADDR_W'(32'h2FFF)) || (off == ADDR_W'(32'h3000)) ||
                    (off == ADDR_W'(32'h4000));
        do_trig   = acc && legal && trig_hit;
        do_wclr   = acc && legal && wclr_hit;
        do_wadd   = acc && legal && wadd_hit;
        do_push   = acc && legal && (trig_hit || pulse_hit || play_hit);
        do_err    = acc && !(legal && (trig_hit || step_hit || wclr_hit || wadd_hit ||
                                       pulse_hit || play_hit || fmr_hit));
    end

    // Channel registers, wait accumulator and saturating drop counter.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            trig_q <= '0;
            num_q  <= '0;
            step_q <= '0;
            wait_q <= '0;
            err_q  <= '0;
        end else begin
            trig_q <= do_trig ? trig_sel : '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (do_trig && trig_sel[c])                  num_q[32*c +: 32]  <= data32;
                if (acc && legal && step_sel[c])             step_q[32*c +: 32] <= data32;
            end
            if (do_trig || do_wclr) wait_q <= '0;
            else if (do_wadd)       wait_q <= wait_q + data32;
            if (do_err && (err_q != 16'hFFFF)) err_q <= err_q + 1'b1;
        end
    end

`ifdef ISA_DECODE_QWAIT_STALL_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Stall countdown register.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) stall_cnt_q <= '0;
        else          stall_cnt_q <= stall_cnt_d;
    end

    // Next state: a non-zero qwait blocks input for exactly N cycles.
    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (do_wadd && (data32 != 32'd0)) begin
                    state_d     = ST_STALL;
                    stall_cnt_d = data32;
                end
            end
            ST_STALL: begin
                stall_cnt_d = stall_cnt_q - 32'd1;
                if (stall_cnt_q == 32'd1) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end
`else
    // Next state: without the stall feature the decoder never leaves IDLE.
    always_comb begin
        state_d = ST_IDLE;
    end
`endif

    // State register.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    isa_decode_mc_fifo #(
        .W     (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk_i      (I_clk),
        .rst_ni     (I_rst_n),
        .push_vld_i (do_push),
        .push_dat_i ({I_isa_addr, I_isa_data}),
        .pop_i      (O_tx_en && I_tx_ready),
        .head_vld_o (O_tx_en),
        .head_dat_o (O_tx_data),
        .full_o     (fifo_full)
    );

    assign O_isa_ready = isa_rdy;
    assign O_Trig      = trig_q;
    assign O_Trig_Num  = num_q;
    assign O_Trig_Step = step_q;
    assign O_Wait      = wait_q;
    assign O_err_cnt   = err_q;
endmodule

// File: tb/tb_isa_decode_mc.sv
// tb_isa_decode_mc: scoreboard bench for isa_decode_mc (default parameters).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Expected TX beats are queued at accept and compared against the FIFO head.
`timescale 1ns/1ps
module tb_isa_decode_mc;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         isa_valid = 1'b0;
    logic         O_isa_ready;
    logic [31:0]  isa_addr = '0;
    logic [31:0]  isa_data = '0;
    logic [3:0]   isa_mask = '0;
    logic [63:0]  O_tx_data;
    logic         O_tx_en;
    logic         tx_ready = 1'b0;
    logic [3:0]   O_Trig;
    logic [127:0] O_Trig_Num;
    logic [127:0] O_Trig_Step;
    logic [31:0]  O_Wait;
    logic [15:0]  O_err_cnt;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    isa_decode_mc dut (
        .I_clk       (clk),
        .I_rst_n     (rst_n),
        .I_isa_valid (isa_valid),
        .O_isa_ready (O_isa_ready),
        .I_isa_addr  (isa_addr),
        .I_isa_data  (isa_data),
        .I_isa_mask  (isa_mask),
        .O_tx_data   (O_tx_data),
        .O_tx_en     (O_tx_en),
        .I_tx_ready  (tx_ready),
        .O_Trig      (O_Trig),
        .O_Trig_Num  (O_Trig_Num),
        .O_Trig_Step (O_Trig_Step),
        .O_Wait      (O_Wait),
        .O_err_cnt   (O_err_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // FIFO head must always equal the oldest outstanding expected beat.
    always @(negedge clk) begin
        if (rst_n && O_tx_en) begin
            if (exp_q.size() == 0) begin
                check("tx_unexpected", 64'(O_tx_en), 64'd0);
            end else begin
                check("tx_head", O_tx_data, exp_q[0]);
                if (tx_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        isa_valid = 1'b1;
        isa_addr  = a;
        isa_data  = d;
        isa_mask  = m;
    endtask

    task automatic wait_accept(input bit push);
        int n = 0;
        logic [63:0] e;
        e = {isa_addr, isa_data};
        @(negedge clk);
        while (!O_isa_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!O_isa_ready) begin
            check("accept_timeout", 64'(O_isa_ready), 64'd1);
            isa_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (push) exp_q.push_back(e);
        #1 isa_valid = 1'b0;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, input bit push);
        drive(a, d, m);
        wait_accept(push);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int lowc;
        // Reset state
        #2;
        check("rst_ready", 64'(O_isa_ready), 64'd0);
        check("rst_tx_en", 64'(O_tx_en), 64'd0);
        check("rst_trig", 64'(O_Trig), 64'd0);
        check("rst_wait", 64'(O_Wait), 64'd0);
        check("rst_err", 64'(O_err_cnt), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tx_ready = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 64'(O_isa_ready), 64'd1);
        @(posedge clk); #1;

        // Qwait then TRIG channel 2: pulse, count, wait cleared, forwarded
        send(32'h0200_2000, 32'd7, 4'hF, 1'b0);
        @(negedge clk);
        check("wait_add7", 64'(O_Wait), 64'd7);
        @(posedge clk); #1;
        send(32'h0200_1010, 32'd5, 4'hF, 1'b1);
        @(negedge clk);
        check("trig_pulse", 64'(O_Trig), 64'b0100);
        check("trig_num2", 64'(O_Trig_Num[95:64]), 64'd5);
        check("trig_clr_wait", 64'(O_Wait), 64'd0);
        check("trig_tx_en", 64'(O_tx_en), 64'd1);
        @(negedge clk);
        check("trig_one_cycle", 64'(O_Trig), 64'd0);
        drain();

        // Step register for channel 1; no push
        @(posedge clk); #1;
        send(32'h0200_100C, 32'd9, 4'hF, 1'b0);
        @(negedge clk);
        check("step_ch1", 64'(O_Trig_Step[63:32]), 64'd9);
        check("step_no_push", 64'(O_tx_en), 64'd0);

        // Wait wrap and clear
        @(posedge clk); #1;
        send(32'h0200_2000, 32'hFFFF_FFF0, 4'hF, 1'b0);
        send(32'h0200_2000, 32'h0000_0020, 4'hF, 1'b0);
        @(negedge clk);
        check("wait_wrap", 64'(O_Wait), 64'h10);
        @(posedge clk); #1;
        send(32'h0200_1FFC, 32'd1, 4'hF, 1'b0);
        @(negedge clk);
        check("wait_clear", 64'(O_Wait), 64'd0);

        // Fill FIFO under backpressure, ninth beat blocked until drain
        @(posedge clk); #1;
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(32'h0200_2400, 32'(i + 100), 4'hF, 1'b1);
        @(negedge clk);
        check("full_ready_low", 64'(O_isa_ready), 64'd0);
        @(posedge clk); #1;
        drive(32'h0200_2400, 32'd108, 4'hF);
        repeat (3) begin
            @(negedge clk);
            check("full_hold", 64'(O_isa_ready), 64'd0);
        end
        @(posedge clk); #1;
        tx_ready = 1'b1;
        wait_accept(1'b1);
        drain();

        // Dropped beats and boundaries
        @(posedge clk); #1;
        send(32'h0200_2400, 32'd1, 4'h7, 1'b0);
        send(32'h0200_0500, 32'd1, 4'hF, 1'b0);
        @(negedge clk);
        check("err_two", 64'(O_err_cnt), 64'd2);
        @(posedge clk); #1;
        send(32'h0200_3000, 32'd1, 4'hF, 1'b0);
        send(32'h0200_2FFF, 32'd1, 4'hF, 1'b0);
        @(negedge clk);
        check("fmr_no_err", 64'(O_err_cnt), 64'd2);
        @(posedge clk); #1;
        send(32'h0200_23F8, 32'hA1, 4'hF, 1'b1);
        send(32'h0200_23F4, 32'hA2, 4'hF, 1'b0);
        send(32'h0205_2000, 32'hA3, 4'hF, 1'b1);
        send(32'h0205_2004, 32'hA4, 4'hF, 1'b0);
        send(32'h0200_1020, 32'hA5, 4'hF, 1'b0);
        @(negedge clk);
        check("err_bounds", 64'(O_err_cnt), 64'd5);
        check("bad_ch_no_trig", 64'(O_Trig), 64'd0);
        drain();

`ifdef ISA_DECODE_QWAIT_STALL_EN
        // Stall for N=3 while the FIFO drains
        @(posedge clk); #1;
        tx_ready = 1'b0;
        send(32'h0200_2500, 32'hB1, 4'hF, 1'b1);
        send(32'h0200_2600, 32'hB2, 4'hF, 1'b1);
        send(32'h0200_2000, 32'd3, 4'hF, 1'b0);
        tx_ready = 1'b1;
        lowc = 0;
        @(negedge clk);
        while (!O_isa_ready && lowc < 20) begin
            lowc++;
            @(negedge clk);
        end
        check("stall_cycles", 64'(lowc), 64'd3);
        check("stall_drained", 64'(exp_q.size()), 64'd0);
        check("stall_wait", 64'(O_Wait), 64'd3);
        @(posedge clk); #1;
        send(32'h0200_2000, 32'd0, 4'hF, 1'b0);
        @(negedge clk);
        check("qwait0_no_stall", 64'(O_isa_ready), 64'd1);

        // Reset during STALL with 4 entries queued
        @(posedge clk); #1;
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(32'h0200_2700, 32'(i), 4'hF, 1'b1);
        send(32'h0200_2000, 32'd50, 4'hF, 1'b0);
        @(negedge clk);
        check("pre_rst_stalled", 64'(O_isa_ready), 64'd0);
        check("pre_rst_tx_en", 64'(O_tx_en), 64'd1);
        #1 rst_n = 1'b0;
`else
        lowc = 0;
        // Reset with 4 entries queued and a trigger pulse in flight
        @(posedge clk); #1;
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(32'h0200_2700, 32'(i), 4'hF, 1'b1);
        send(32'h0200_1000, 32'hAB, 4'hF, 1'b1);
        check("pre_rst_trig", 64'(O_Trig), 64'd1);
        check("pre_rst_tx_en", 64'(O_tx_en), 64'd1);
        rst_n = 1'b0;
`endif
        #1;
        exp_q.delete();
        check("mid_rst_tx_en", 64'(O_tx_en), 64'd0);
        check("mid_rst_tx_data", O_tx_data, 64'd0);
        check("mid_rst_trig", 64'(O_Trig), 64'd0);
        check("mid_rst_num", O_Trig_Num[63:0] | O_Trig_Num[127:64], 64'd0);
        check("mid_rst_step", O_Trig_Step[63:0] | O_Trig_Step[127:64], 64'd0);
        check("mid_rst_wait", 64'(O_Wait), 64'd0);
        check("mid_rst_err", 64'(O_err_cnt), 64'd0);
        check("mid_rst_ready", 64'(O_isa_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tx_ready = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(O_isa_ready), 64'd1);
        check("post_rst_tx_en", 64'(O_tx_en), 64'd0);

        // Play-range lower bound works after reset
        @(posedge clk); #1;
        send(32'h0200_8000, 32'hC0FFEE, 4'hF, 1'b1);
        drain();

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
